int8_word_packer: RTL and testbench
===================================

# int8_word_packer

Downstream consumer of the FP16→INT8 converter: accepts one sign-magnitude INT8 byte per `input_valid` pulse and converts it to two's complement. It packs four consecutive bytes into a little-endian 32-bit word and buffers completed words in a small FIFO. The FIFO exists because the converter cannot be stalled; words leave through a valid/ready handshake toward the memory/bus writer.

## Interface
- `FIFO_DEPTH`, 4: word FIFO depth; power of two, ≥2.
- `AW`, log2(FIFO_DEPTH) = 2: FIFO pointer width; derived, not overridden.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `data_i`  in  8  converter output; bit7 = sign, [6:0] = magnitude.
- `input_valid`  in  1  one-cycle pulse; `data_i` is valid this cycle. Driven by the converter's `output_update`.
- `flush`  in  1  one-cycle pulse; emits any partial word.
- `word_o`  out  32  FIFO head word.
- `byte_en_o`  out  4  FIFO head lane mask; bit k covers `word_o[8k+7:8k]`.
- `word_valid`  out  1  FIFO non-empty.
- `word_ready`  in  1  consumer accepts the head when `word_valid & word_ready`.
- `fifo_level`  out  AW+1  number of stored words.
- `drop_err`  out  1  sticky; at least one word was lost to a full FIFO.

## Operation
- Conversion (combinational on `data_i`):
  - sign=0 → byte unchanged.
  - sign=1, mag≠0 → −mag in two's complement.
  - 0x80 (negative zero) → 0x00.
  - 0xFF (converter overflow code) → 0x81 (−127).
- Accumulator: 24-bit `acc` plus a 2-bit `lane_cnt` (0..3).
  - Converted byte goes to lane `lane_cnt`; the first byte received occupies bits [7:0].
- Word completion: on a sampled `input_valid` with `lane_cnt==3`:
  - push `{byte, acc[23:0]}` with `byte_en=4'b1111`;
  - `lane_cnt`→0, `acc` cleared.
- Flush with `lane_cnt>0` and no `input_valid`:
  - push `acc` zero-extended with `byte_en` = the low `lane_cnt` bits set (1→0001, 2→0011, 3→0111);
  - unused bytes are 0; `lane_cnt`→0.
- Flush with `lane_cnt==0`: no-op.
- `flush` and `input_valid` in the same cycle: the byte is inserted first, then the flush applies to the result.
  - If the byte completes a word, exactly one word is pushed (1111).
  - Otherwise one partial word is pushed that includes the byte.
- FIFO: register array with `wr_ptr`/`rd_ptr` of AW+1 bits (MSB = wrap bit).
  - full = pointer MSBs differ and lower bits equal; empty = pointers equal.
  - `word_o`/`byte_en_o` read combinationally from `mem[rd_ptr]`.
- Pop: `word_valid & word_ready` advances `rd_ptr`. `word_ready` while empty is ignored.
- Push while full:
  - with a pop in the same cycle → accepted, level unchanged;
  - without a pop → word discarded, `drop_err`←1.
  - In both cases the accumulator clears as for a normal push.
- `drop_err` is cleared only by reset.

## Timing
- Reset (`rst`=0, asynchronous) — all of these take effect immediately:
  - `lane_cnt`=0, `acc`=0, pointers=0, `drop_err`=0;
  - outputs: `word_valid`=0, `fifo_level`=0, `word_o`=0, `byte_en_o`=0 (memory cleared).
- Reset during operation discards the partial word and all FIFO contents.
- Latency: 4th byte sampled at edge N → `word_valid`=1 in the cycle after N (FIFO previously empty). Flush has the same one-edge latency.
- Throughput: one byte per cycle sustained; one word every 4 cycles at most. The consumer must pop ≥1 word per 4 cycles to avoid loss.
- `fifo_level` updates on the push/pop edge: +1 push only, −1 pop only, unchanged for both or neither (including a dropped push while full).
- `word_o` is stable while `word_valid & ~word_ready`.

## Test plan
- Pack and convert: bytes 0x01, 0x85, 0xFF, 0x7F on consecutive cycles, `word_ready`=1 → one word 0x7F81FB01, `byte_en_o`=1111, one cycle after the 4th byte.
- Negative zero and partial flush: bytes 0x80, 0x05, then `flush` → word 0x00000500, `byte_en_o`=0011; a second `flush` produces nothing.
- Flush coinciding with the 4th byte: bytes 0x11, 0x22, 0x33, then 0x44 with `flush` → single word 0x44332211, `byte_en_o`=1111, `fifo_level` ends at 1 before the pop.
- Backpressure and overflow: `word_ready`=0, 20 bytes (5 words, FIFO_DEPTH=4) → `fifo_level`=4, `drop_err`=1, 5th word lost. Then `word_ready`=1 → the first four words drain in order, `word_valid`→0.
- Full with simultaneous push/pop: FIFO full, 4th byte arrives in the same cycle as a pop → no drop, `drop_err` stays 0, `fifo_level` stays 4.
- Async reset during operation: reset asserted after 2 bytes with 3 words queued → `word_valid`, `fifo_level`, `drop_err`=0 immediately. After release, bytes 0x01..0x04 → word 0x04030201.

Source files
------------

// File: rtl/int8_word_packer.sv
// int8_word_packer: converts sign-magnitude INT8 bytes to two's complement,
// packs four of them little-endian into a 32-bit word and queues finished
// words in a small FIFO drained through a valid/ready handshake.
module int8_word_packer #(
  parameter  int FIFO_DEPTH = 4,
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    data_i,
  input  logic          input_valid,
  input  logic          flush,
  output logic [31:0]   word_o,
  output logic [3:0]    byte_en_o,
  output logic          word_valid,
  input  logic          word_ready,
  output logic [AW:0]   fifo_level,
  output logic          drop_err
);

  localparam logic [AW:0] PTR_ONE = 1;

  logic [7:0]  conv_byte;
  logic [23:0] acc;
  logic [1:0]  lane_cnt;
  logic [31:0] stage_word;
  logic [2:0]  cnt_after;
  logic [3:0]  stage_be;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic        wr_en;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [31:0] word_mem [FIFO_DEPTH];
  logic [3:0]  be_mem   [FIFO_DEPTH];

  // Sign-magnitude to two's complement; negative zero maps to 0 and the
  // converter's overflow code 0xFF lands on -127.
  always_comb begin
    conv_byte = data_i;
    if (data_i == 8'hFF) begin
      conv_byte = 8'h81;
    end else if (data_i[7]) begin
      conv_byte = 8'd0 - {1'b0, data_i[6:0]};
    end
  end

  // Insert the incoming byte into its lane first, then decide whether the
  // result leaves as a complete word or as a flushed partial word.
  always_comb begin
    stage_word = {8'h00, acc};
    if (input_valid) begin
      case (lane_cnt)
        2'd0:    stage_word[7:0]   = conv_byte;
        2'd1:    stage_word[15:8]  = conv_byte;
        2'd2:    stage_word[23:16] = conv_byte;
        default: stage_word[31:24] = conv_byte;
      endcase
    end
    cnt_after = {1'b0, lane_cnt} + {2'b00, input_valid};
    case (cnt_after)
      3'd1:    stage_be = 4'b0001;
      3'd2:    stage_be = 4'b0011;
      3'd3:    stage_be = 4'b0111;
      3'd4:    stage_be = 4'b1111;
      default: stage_be = 4'b0000;
    endcase
    push = (cnt_after == 3'd4) || (flush && (cnt_after != 3'd0));
  end

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = ~empty & word_ready;
  assign wr_en      = push & (~full | pop);
  assign word_valid = ~empty;
  assign fifo_level = wr_ptr - rd_ptr;
  assign word_o     = word_mem[rd_ptr[AW-1:0]];
  assign byte_en_o  = be_mem[rd_ptr[AW-1:0]];

  // Accumulator and lane counter; any push, even a dropped one, starts a new word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      lane_cnt <= '0;
    end else if (push) begin
      acc      <= '0;
      lane_cnt <= '0;
    end else begin
      acc      <= stage_word[23:0];
      lane_cnt <= cnt_after[1:0];
    end
  end

  // FIFO storage and pointers; a push into a full FIFO survives only if the head pops this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_err <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        word_mem[i] <= '0;
        be_mem[i]   <= '0;
      end
    end else begin
      if (wr_en) begin
        word_mem[wr_ptr[AW-1:0]] <= stage_word;
        be_mem[wr_ptr[AW-1:0]]   <= stage_be;
        wr_ptr                   <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !wr_en) begin
        drop_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_int8_word_packer.sv
// tb_int8_word_packer: table-driven vectors for conversion, packing and
// flushing, plus hand-written sequences for overflow, full push/pop and
// asynchronous reset.
module tb_int8_word_packer;

  logic        clk;
  logic        rst;
  logic [7:0]  data_i;
  logic        input_valid;
  logic        flush;
  logic [31:0] word_o;
  logic [3:0]  byte_en_o;
  logic        word_valid;
  logic        word_ready;
  logic [2:0]  fifo_level;
  logic        drop_err;

  int n_vec;
  int n_err;

  typedef struct {
    logic [7:0]  data;
    logic        iv;
    logic        fl;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_word;
    logic [3:0]  exp_be;
    logic [2:0]  exp_level;
    logic        exp_drop;
  } vec_t;

  vec_t vecs [17];

  int8_word_packer #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .input_valid(input_valid),
    .flush      (flush),
    .word_o     (word_o),
    .byte_en_o  (byte_en_o),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .fifo_level (fifo_level),
    .drop_err   (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it in, and return 1 ns after the edge.
  task automatic step(input logic [7:0] d, input logic iv, input logic fl, input logic rdy);
    data_i      = d;
    input_valid = iv;
    flush       = fl;
    word_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    data_i      = 8'h00;
    input_valid = 1'b0;
    flush       = 1'b0;
    word_ready  = 1'b0;
    #1 rst = 1'b0;
    #1 rst = 1'b1;
  endtask

  function automatic logic [31:0] seq_word(input int w);
    seq_word = {8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)};
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    data_i = 8'h00;
    input_valid = 1'b0;
    flush = 1'b0;
    word_ready = 1'b0;

    //              data   iv    fl    rdy   valid word          be       lvl   drop
    vecs[0]  = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'b0000, 3'd0, 1'b0};
    vecs[1]  = '{8'h85, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'b0000, 3'd0, 1'b0};
    vecs[2]  = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'b0000, 3'd0, 1'b0};
    vecs[3]  = '{8'h7F, 1'b1, 1'b0, 1'b1, 1'b1, 32'h7F81FB01, 4'b1111, 3'd1, 1'b0};
    vecs[4]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'b0000, 3'd0, 1'b0};
    vecs[5]  = '{8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        4'b0000, 3'd0, 1'b0};
    vecs[6]  = '{8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        4'b0000, 3'd0, 1'b0};
    vecs[7]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000500, 4'b0011, 3'd1, 1'b0};
    vecs[8]  = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        4'b0000, 3'd0, 1'b0};
    vecs[9]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        4'b0000, 3'd0, 1'b0};
    vecs[10] = '{8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        4'b0000, 3'd0, 1'b0};
    vecs[11] = '{8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        4'b0000, 3'd0, 1'b0};
    vecs[12] = '{8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        4'b0000, 3'd0, 1'b0};
    vecs[13] = '{8'h44, 1'b1, 1'b1, 1'b0, 1'b1, 32'h44332211, 4'b1111, 3'd1, 1'b0};
    vecs[14] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'b0000, 3'd0, 1'b0};
    vecs[15] = '{8'h83, 1'b1, 1'b1, 1'b0, 1'b1, 32'h000000FD, 4'b0001, 3'd1, 1'b0};
    vecs[16] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'b0000, 3'd0, 1'b0};

    // Reset state while reset is held
    #2;
    check("reset valid", 32'(word_valid), 32'd0);
    check("reset level", 32'(fifo_level), 32'd0);
    check("reset drop",  32'(drop_err),   32'd0);
    check("reset word",  word_o,          32'h0);
    check("reset be",    32'(byte_en_o),  32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].data, vecs[i].iv, vecs[i].fl, vecs[i].rdy);
      check($sformatf("vec%0d valid", i), 32'(word_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d level", i), 32'(fifo_level), 32'(vecs[i].exp_level));
      check($sformatf("vec%0d drop", i),  32'(drop_err),   32'(vecs[i].exp_drop));
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d word", i), word_o,         vecs[i].exp_word);
        check($sformatf("vec%0d be", i),   32'(byte_en_o), 32'(vecs[i].exp_be));
      end
    end

    // Backpressure and overflow: five words into a four-deep FIFO
    for (int i = 0; i < 20; i++) begin
      step(8'(i + 1), 1'b1, 1'b0, 1'b0);
    end
    step(8'h00, 1'b0, 1'b0, 1'b0);
    check("ovf level", 32'(fifo_level), 32'd4);
    check("ovf drop",  32'(drop_err),   32'd1);
    for (int w = 0; w < 4; w++) begin
      check($sformatf("drain%0d valid", w), 32'(word_valid), 32'd1);
      check($sformatf("drain%0d word", w),  word_o,          seq_word(w));
      check($sformatf("drain%0d be", w),    32'(byte_en_o),  32'hF);
      step(8'h00, 1'b0, 1'b0, 1'b1);
    end
    check("drained valid", 32'(word_valid), 32'd0);
    check("drained level", 32'(fifo_level), 32'd0);
    check("drop sticky",   32'(drop_err),   32'd1);
    pulse_reset();
    check("reset clears drop", 32'(drop_err), 32'd0);

    // Full FIFO with push and pop on the same edge
    for (int i = 0; i < 16; i++) begin
      step(8'(i + 1), 1'b1, 1'b0, 1'b0);
    end
    check("full level", 32'(fifo_level), 32'd4);
    step(8'h11, 1'b1, 1'b0, 1'b0);
    step(8'h22, 1'b1, 1'b0, 1'b0);
    step(8'h33, 1'b1, 1'b0, 1'b0);
    step(8'h44, 1'b1, 1'b0, 1'b1);
    check("pushpop level", 32'(fifo_level), 32'd4);
    check("pushpop drop",  32'(drop_err),   32'd0);
    for (int w = 1; w < 4; w++) begin
      check($sformatf("pp head%0d", w), word_o, seq_word(w));
      step(8'h00, 1'b0, 1'b0, 1'b1);
    end
    check("pp last word", word_o, 32'h44332211);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    check("pp empty", 32'(word_valid), 32'd0);

    // Asynchronous reset with three words queued and two bytes pending
    for (int i = 0; i < 14; i++) begin
      step(8'(i + 1), 1'b1, 1'b0, 1'b0);
    end
    step(8'h00, 1'b0, 1'b0, 1'b0);
    check("pre-reset level", 32'(fifo_level), 32'd3);
    #2 rst = 1'b0;
    #1;
    check("async valid", 32'(word_valid), 32'd0);
    check("async level", 32'(fifo_level), 32'd0);
    check("async drop",  32'(drop_err),   32'd0);
    check("async word",  word_o,          32'h0);
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(8'(i + 1), 1'b1, 1'b0, 1'b0);
    end
    check("post-reset valid", 32'(word_valid), 32'd1);
    check("post-reset word",  word_o,          32'h04030201);
    check("post-reset be",    32'(byte_en_o),  32'hF);
    check("post-reset level", 32'(fifo_level), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
